conv_bus_arbiter: RTL and testbench
===================================

// Module: conv_bus_arbiter
// PURPOSE
//  Shares one address bus and one data bus between the conv read bridge (RD) and the conv write bridge (WR).
//  Replaces the combinational arvalid/awvalid address mux with a registered round-robin arbiter.
//  At most one transaction is in flight at a time: address phase, then data phase, then bus turnaround.
//  Sits between the bridges and the system bus. Drives link direction (rd/wr data enables) for the unit.
// PARAMETERS
//  ADDR_W   28   address width
//  ID_W     4    user-id width
//  LEN_W    4    burst length field; beats = len+1
//  TURN_CYC 1    idle cycles inserted after each data phase (0..3; 0 = none)
//  TMO_CYC  255  watchdog limit in cycles (used only with CONV_ARB_TMO_EN)
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       async active-low reset
//  rd_valid     in   1       RD request
//  rd_addr      in   ADDR_W  RD start address
//  rd_len       in   LEN_W   RD burst length
//  rd_id        in   ID_W    RD user id
//  rd_ready     out  1       RD request accepted (1-cycle pulse)
//  wr_valid     in   1       WR request
//  wr_addr      in   ADDR_W  WR start address
//  wr_len       in   LEN_W   WR burst length
//  wr_id        in   ID_W    WR user id
//  wr_ready     out  1       WR request accepted (1-cycle pulse)
//  addr         out  ADDR_W  shared address bus
//  arvalid      out  1       read address valid
//  arlen        out  LEN_W   read length
//  aruser_id    out  ID_W    read id
//  arready      in   1       read address ready
//  awvalid      out  1       write address valid
//  awlen        out  LEN_W   write length
//  awuser_id    out  ID_W    write id
//  awready      in   1       write address ready
//  rvalid       in   1       read data beat valid
//  rlast        in   1       last read beat
//  wready       in   1       write data beat accepted
//  wuser_last   in   1       last write beat accepted
//  rd_data_en   out  1       RD owns data bus (link_read)
//  wr_data_en   out  1       WR drives data bus (link_write)
//  len_err      out  1       sticky: beat count at last != len+1
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, last_grant=WR (so RD wins the first tie), beat count 0, len_err 0.
//  Reset mid-burst aborts immediately. No bus output stays asserted.
//  FSM: IDLE -> RA|WA -> RD|WD -> TURN -> IDLE. TURN is skipped when TURN_CYC=0.
//  IDLE arbitration:
//   - Only rd_valid -> RD. Only wr_valid -> WR.
//   - Both -> the side not equal to last_grant.
//   - The grant latches addr/len/id, pulses the matching *_ready for 1 cycle, updates last_grant, and enters RA|WA next cycle.
//  RA: arvalid=1, addr=latched addr, arlen/aruser_id held stable until arready. On arready -> RD next cycle, arvalid=0.
//  WA: same as RA, using awvalid/awready -> WD.
//  RD: rd_data_en=1. Count rvalid beats. Done on rvalid&&rlast.
//  WD: wr_data_en=1. Count wready beats. Done on wready&&wuser_last.
//  At done: if count+1 != len+1, set len_err (sticky until reset). Enter TURN.
//  addr bus: 0 when not in RA/WA. arvalid and awvalid are never both 1. rd_data_en and wr_data_en are never both 1.
//  Requests arriving while busy are held off (ready=0). Requesters must hold valid and payload until ready.
//  Address handshake latency: grant cycle + 1 -> *valid. Minimum turnaround from last beat to next grant = TURN_CYC+1 cycles.
//  Beat count is LEN_W+1 bits and saturates (no wrap). rlast without rvalid is ignored.
// CONFIGURATION
//  CONV_ARB_TMO_EN defined:
//   - A watchdog counts cycles in RA/WA/RD/WD and clears on each handshake or beat.
//   - Reaching TMO_CYC sets the sticky output tmo_err (1 bit, extra port), drops all valids and enables, and forces TURN.
//  CONV_ARB_TMO_EN undefined: no watchdog, no tmo_err port. The FSM waits indefinitely.
// TESTING
//  1. rd_valid=wr_valid=1 in the same cycle after reset.
//     -> RD granted first (rd_ready pulse), then WR after RD completes plus TURN_CYC.
//  2. RD len=3, arready delayed 5 cycles, 4 rvalid beats with rlast on the 4th.
//     -> arvalid held 6 cycles with stable addr; len_err=0; busy drops TURN_CYC+1 cycles after the last beat.
//  3. WR len=3 with wuser_last on beat 2.
//     -> len_err=1, sticky across later transactions until rst_n.
//  4. Both requests held continuously for 6 transactions.
//     -> grants alternate RD,WR,RD,WR,RD,WR.
//     -> arvalid&awvalid never both 1; rd_data_en&wr_data_en never both 1.
//  5. rst_n low during WD beat 2.
//     -> all outputs 0 asynchronously; after release the next grant is RD.
//  6. CONV_ARB_TMO_EN, TMO_CYC=16, arready never asserted.
//     -> tmo_err=1 at cycle 16 of RA, arvalid drops, FSM returns to IDLE.

Source files
------------

// File: rtl/conv_bus_arbiter_if.sv
// Request, address-bus and data-bus signals shared by the conv bridges, the arbiter and the system bus.
// The master modport is the arbiter's view. The slave modport is the view of the bridges and the bus.
interface conv_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned LEN_W  = 4
);
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic [ID_W-1:0]   rd_id;
  logic              rd_ready;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  wr_len;
  logic [ID_W-1:0]   wr_id;
  logic              wr_ready;
  logic [ADDR_W-1:0] addr;
  logic              arvalid;
  logic [LEN_W-1:0]  arlen;
  logic [ID_W-1:0]   aruser_id;
  logic              arready;
  logic              awvalid;
  logic [LEN_W-1:0]  awlen;
  logic [ID_W-1:0]   awuser_id;
  logic              awready;
  logic              rvalid;
  logic              rlast;
  logic              wready;
  logic              wuser_last;
  logic              rd_data_en;
  logic              wr_data_en;
  logic              len_err;
  logic              busy;

  modport master (
    input  rd_valid, rd_addr, rd_len, rd_id,
    input  wr_valid, wr_addr, wr_len, wr_id,
    input  arready, awready, rvalid, rlast, wready, wuser_last,
    output rd_ready, wr_ready, addr, arvalid, arlen, aruser_id,
    output awvalid, awlen, awuser_id, rd_data_en, wr_data_en, len_err, busy
  );

  modport slave (
    output rd_valid, rd_addr, rd_len, rd_id,
    output wr_valid, wr_addr, wr_len, wr_id,
    output arready, awready, rvalid, rlast, wready, wuser_last,
    input  rd_ready, wr_ready, addr, arvalid, arlen, aruser_id,
    input  awvalid, awlen, awuser_id, rd_data_en, wr_data_en, len_err, busy
  );
endinterface

// File: rtl/conv_bus_arbiter.sv
// Registered round-robin arbiter that serialises conv RD/WR bridge transactions on the shared buses.
// Define CONV_ARB_TMO_EN to add the phase watchdog and the tmo_err output.
module conv_bus_arbiter #(
  parameter int unsigned ADDR_W   = 28,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned TMO_CYC  = 255
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CONV_ARB_TMO_EN
  output logic tmo_err,
`endif
  conv_bus_arbiter_if.master bus
);

  typedef enum logic [2:0] {StIdle, StRa, StWa, StRd, StWd, StTurn} state_e;

  localparam logic [LEN_W:0] CntMax   = '1;
  localparam logic [1:0]     TurnLast = (TURN_CYC == 0) ? 2'd0 : 2'(TURN_CYC - 1);
  localparam state_e         StPost   = (TURN_CYC == 0) ? StIdle : StTurn;

  if (TURN_CYC > 3 || TMO_CYC == 0) begin : g_bad_cfg
    $error("conv_bus_arbiter: TURN_CYC must be 0..3 and TMO_CYC non-zero");
  end

  state_e            state_q, state_d;
  logic              last_wr_q, last_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LEN_W:0]    cnt_q, cnt_d;
  logic [1:0]        turn_q, turn_d;
  logic              len_err_q, len_err_d;
  logic              grant_rd, grant_wr, done;

`ifdef CONV_ARB_TMO_EN
  localparam int unsigned     TmoW    = $clog2(TMO_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO_CYC - 1);

  logic [TmoW-1:0] wdog_q, wdog_d;
  logic            tmo_q, tmo_d;
  logic            in_phase, progress;
`endif

  // Grants are qualified by rst_n so no ready pulse can escape while reset is held.
  assign grant_rd = rst_n && (state_q == StIdle) && bus.rd_valid &&
                    (!bus.wr_valid || last_wr_q);
  assign grant_wr = rst_n && (state_q == StIdle) && bus.wr_valid &&
                    !(bus.rd_valid && last_wr_q);

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    addr_d    = addr_q;
    len_d     = len_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    turn_d    = turn_q;
    len_err_d = len_err_q;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_rd) begin
          state_d   = StRa;
          last_wr_d = 1'b0;
          addr_d    = bus.rd_addr;
          len_d     = bus.rd_len;
          id_d      = bus.rd_id;
          cnt_d     = '0;
        end else if (grant_wr) begin
          state_d   = StWa;
          last_wr_d = 1'b1;
          addr_d    = bus.wr_addr;
          len_d     = bus.wr_len;
          id_d      = bus.wr_id;
          cnt_d     = '0;
        end
      end
      StRa: if (bus.arready) state_d = StRd;
      StWa: if (bus.awready) state_d = StWd;
      StRd: begin
        if (bus.rvalid) begin
          if (bus.rlast) done = 1'b1;
          else           cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end
      end
      StWd: begin
        if (bus.wready) begin
          if (bus.wuser_last) done = 1'b1;
          else                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end
      end
      StTurn: begin
        if (turn_q == TurnLast) state_d = StIdle;
        else                    turn_d  = turn_q + 2'd1;
      end
      default: state_d = StIdle;
    endcase

    // cnt_q holds the beats before the final one, so a correct burst ends with cnt_q == len.
    if (done) begin
      if (cnt_q != {1'b0, len_q}) len_err_d = 1'b1;
      cnt_d   = '0;
      turn_d  = 2'd0;
      state_d = StPost;
    end

`ifdef CONV_ARB_TMO_EN
    tmo_d    = tmo_q;
    in_phase = (state_q == StRa) || (state_q == StWa) || (state_q == StRd) || (state_q == StWd);
    progress = ((state_q == StRa) && bus.arready) || ((state_q == StWa) && bus.awready) ||
               ((state_q == StRd) && bus.rvalid)  || ((state_q == StWd) && bus.wready);
    wdog_d   = (in_phase && !progress) ? wdog_q + 1'b1 : '0;
    if (in_phase && !progress && (wdog_q == TmoLast)) begin
      tmo_d   = 1'b1;
      wdog_d  = '0;
      cnt_d   = '0;
      turn_d  = 2'd0;
      state_d = StPost;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_wr_q <= 1'b1;
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      turn_q    <= 2'd0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      turn_q    <= turn_d;
      len_err_q <= len_err_d;
    end
  end

`ifdef CONV_ARB_TMO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end

  assign tmo_err = tmo_q;
`endif

  assign bus.rd_ready   = grant_rd;
  assign bus.wr_ready   = grant_wr;
  assign bus.arvalid    = (state_q == StRa);
  assign bus.awvalid    = (state_q == StWa);
  assign bus.addr       = ((state_q == StRa) || (state_q == StWa)) ? addr_q : '0;
  assign bus.arlen      = (state_q == StRa) ? len_q : '0;
  assign bus.aruser_id  = (state_q == StRa) ? id_q : '0;
  assign bus.awlen      = (state_q == StWa) ? len_q : '0;
  assign bus.awuser_id  = (state_q == StWa) ? id_q : '0;
  assign bus.rd_data_en = (state_q == StRd);
  assign bus.wr_data_en = (state_q == StWd);
  assign bus.len_err    = len_err_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_conv_bus_arbiter.sv
// Self-checking bench for conv_bus_arbiter: random traffic against a rule-level arbitration model.
module tb_conv_bus_arbiter;
  localparam int unsigned ADDR_W = 28, ID_W = 4, LEN_W = 4, TURN_CYC = 1, TMO_CYC = 16;
  localparam int RD = 0, WR = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_bus_arbiter_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();
`ifdef CONV_ARB_TMO_EN
  logic tmo_err;
`endif

  conv_bus_arbiter #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W), .TURN_CYC(TURN_CYC), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef CONV_ARB_TMO_EN
    .tmo_err(tmo_err),
`endif
    .bus(bus)
  );

  typedef struct {
    bit                first_ok;
    int                vcyc;
    logic [ADDR_W-1:0] a;
    logic [LEN_W-1:0]  l;
    logic [ID_W-1:0]   id;
    bit                stable;
    int                en_bad;
    int                drop;
    bit                timeout;
  } obs_t;

  int errors = 0, checks = 0, viol = 0;
  bit last_rd;       // model: side of the most recent grant (0 = WR)
  bit len_err_exp;
  logic [ADDR_W-1:0] m_addr[2], s_addr[2];
  logic [LEN_W-1:0]  m_len[2], s_len[2];
  logic [ID_W-1:0]   m_id[2], s_id[2];

  always @(negedge clk) begin
    if (rst_n) begin
      if ((bus.arvalid && bus.awvalid) || (bus.rd_data_en && bus.wr_data_en) ||
          (!bus.arvalid && !bus.awvalid && bus.addr != '0)) viol++;
    end
  end

  initial begin
    #800000;
    $display("FAIL global_timeout time=%0t limit=800000", $time);
    $fatal(1);
  end

  function automatic int exp_side(bit rv, bit wv);
    if (rv && wv) return last_rd ? WR : RD;
    return rv ? RD : WR;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({bus.rd_ready, bus.wr_ready, bus.arvalid, bus.awvalid, bus.rd_data_en,
                bus.wr_data_en, bus.len_err, bus.busy, bus.addr, bus.arlen, bus.aruser_id,
                bus.awlen, bus.awuser_id});
  endfunction

  task automatic clear_inputs();
    bus.rd_valid = 0; bus.rd_addr = '0; bus.rd_len = '0; bus.rd_id = '0;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_len = '0; bus.wr_id = '0;
    bus.arready = 0; bus.awready = 0; bus.rvalid = 0; bus.rlast = 0;
    bus.wready = 0; bus.wuser_last = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd = 1'b0;
    len_err_exp = 1'b0;
  endtask

  task automatic stage(input int s);
    s_addr[s] = ADDR_W'($urandom);
    s_len[s]  = LEN_W'($urandom_range(0, 7));
    s_id[s]   = ID_W'($urandom);
  endtask

  // Raise a request with the staged payload and remember it in the model.
  task automatic req(input int s);
    m_addr[s] = s_addr[s]; m_len[s] = s_len[s]; m_id[s] = s_id[s];
    if (s == RD) begin
      bus.rd_valid = 1; bus.rd_addr = s_addr[s]; bus.rd_len = s_len[s]; bus.rd_id = s_id[s];
    end else begin
      bus.wr_valid = 1; bus.wr_addr = s_addr[s]; bus.wr_len = s_len[s]; bus.wr_id = s_id[s];
    end
  endtask

  task automatic wait_grant(output int side, output int waited);
    side = -1;
    waited = 0;
    for (int i = 0; i < 40 && side == -1; i++) begin
      if (bus.rd_ready && bus.wr_ready) side = 2;
      else if (bus.rd_ready) side = RD;
      else if (bus.wr_ready) side = WR;
      if (side == -1) begin
        @(negedge clk); #1;
        waited++;
      end
    end
  endtask

  // Bus-side responder for one granted transaction; returns what it observed.
  task automatic serve(input int side, input bit nrd, input bit nwr, input int ar_delay,
                       input int nbeats, input bit ghost, output obs_t o);
    bit hs = 0;
    int sent = 0;
    bit go, gl, v;
    o = '{first_ok: 0, vcyc: 0, a: '0, l: '0, id: '0, stable: 1, en_bad: 0, drop: 0,
          timeout: 0};
    for (int c = 0; c < 64 && !hs; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (nrd) req(RD); else if (side == RD) bus.rd_valid = 0;
        if (nwr) req(WR); else if (side == WR) bus.wr_valid = 0;
      end
      if (side == RD) bus.arready = (c >= ar_delay); else bus.awready = (c >= ar_delay);
      #1;
      v = (side == RD) ? bus.arvalid : bus.awvalid;
      if (c == 0) o.first_ok = v;
      if (v) begin
        o.vcyc++;
        if (o.vcyc == 1) begin
          o.a = bus.addr;
          o.l = (side == RD) ? bus.arlen : bus.awlen;
          o.id = (side == RD) ? bus.aruser_id : bus.awuser_id;
        end else if (o.a !== bus.addr || o.l !== ((side == RD) ? bus.arlen : bus.awlen) ||
                     o.id !== ((side == RD) ? bus.aruser_id : bus.awuser_id)) begin
          o.stable = 0;
        end
        if (c >= ar_delay) hs = 1;
      end
    end
    if (!hs) o.timeout = 1;
    for (int c = 0; c < 200 && sent < nbeats && hs; c++) begin
      @(negedge clk);
      bus.arready = 0; bus.awready = 0;
      go = ($urandom_range(0, 2) != 0);
      gl = ghost && !go && ($urandom_range(0, 1) == 1);
      if (side == RD) begin
        bus.rvalid = go; bus.rlast = go ? (sent == nbeats - 1) : gl;
      end else begin
        bus.wready = go; bus.wuser_last = go ? (sent == nbeats - 1) : gl;
      end
      #1;
      if (!((side == RD) ? bus.rd_data_en : bus.wr_data_en)) o.en_bad++;
      if (go) sent++;
    end
    if (sent < nbeats) o.timeout = 1;
    for (int j = 1; j <= 10 && o.drop == 0; j++) begin
      @(negedge clk);
      bus.arready = 0; bus.awready = 0;
      bus.rvalid = 0; bus.rlast = 0; bus.wready = 0; bus.wuser_last = 0;
      #1;
      if (bus.rd_data_en || bus.wr_data_en || bus.arvalid || bus.awvalid) o.en_bad++;
      if (!bus.busy) o.drop = j;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stage(RD); stage(WR); req(RD); req(WR);
    bus.arready = 1; bus.rvalid = 1; bus.rlast = 1;
    #3;
    checks++;
    if (all_outs() !== 64'd0)
      begin errors++; $display("FAIL reset_held outs=%0h want=0", all_outs()); end
    clear_inputs();
    @(negedge clk); rst_n = 1'b1; last_rd = 0; len_err_exp = 0;
    @(negedge clk); #1;
    checks++;
    if (all_outs() !== 64'd0)
      begin errors++; $display("FAIL reset_idle outs=%0h want=0", all_outs()); end
  endtask

  task automatic test_tie();
    int side, waited;
    obs_t o;
    do_reset();
    stage(RD); stage(WR); req(RD); req(WR);
    #1; wait_grant(side, waited);
    checks++;
    if (side !== RD || waited !== 0)
      begin errors++; $display("FAIL tie_first side=%0d wait=%0d want=0/0", side, waited); end
    last_rd = 1;
    serve(RD, 0, 0, 1, m_len[RD] + 1, 0, o);
    wait_grant(side, waited);
    checks++;
    if (side !== WR || waited !== 0 || o.drop !== TURN_CYC + 1)
      begin errors++; $display("FAIL tie_second side=%0d wait=%0d drop=%0d want=1/0/%0d",
                               side, waited, o.drop, TURN_CYC + 1); end
    last_rd = 0;
    serve(WR, 0, 0, 0, m_len[WR] + 1, 0, o);
  endtask

  task automatic test_ar_delay();
    int side, waited;
    obs_t o;
    do_reset();
    stage(RD); s_len[RD] = 4'd3; req(RD);
    #1; wait_grant(side, waited);
    checks++;
    if (side !== RD) begin errors++; $display("FAIL ard_grant side=%0d want=0", side); end
    last_rd = 1;
    serve(RD, 0, 0, 5, 4, 1, o);
    checks++;
    if (!o.first_ok || o.vcyc !== 6 || !o.stable)
      begin errors++; $display("FAIL ard_valid first=%0d cyc=%0d stable=%0d want=1/6/1",
                               o.first_ok, o.vcyc, o.stable); end
    checks++;
    if ({o.a, o.l, o.id} !== {m_addr[RD], 4'd3, m_id[RD]})
      begin errors++; $display("FAIL ard_payload got=%0h/%0h/%0h want=%0h/3/%0h",
                               o.a, o.l, o.id, m_addr[RD], m_id[RD]); end
    checks++;
    if (bus.len_err !== 1'b0 || o.drop !== TURN_CYC + 1 || o.en_bad !== 0)
      begin errors++; $display("FAIL ard_end len_err=%0d drop=%0d en_bad=%0d want=0/%0d/0",
                               bus.len_err, o.drop, o.en_bad, TURN_CYC + 1); end
  endtask

  task automatic test_len_err();
    int side, waited;
    obs_t o;
    do_reset();
    stage(WR); s_len[WR] = 4'd3; req(WR);
    #1; wait_grant(side, waited);
    last_rd = 0;
    serve(WR, 0, 0, 0, 2, 0, o);
    checks++;
    if (bus.len_err !== 1'b1) begin errors++; $display("FAIL len_err_set got=%0d want=1",
                                                        bus.len_err); end
    for (int k = 0; k < 2; k++) begin
      stage(k); req(k);
      #1; wait_grant(side, waited);
      serve(side, 0, 0, 1, m_len[k] + 1, 0, o);
      checks++;
      if (bus.len_err !== 1'b1 || side !== k)
        begin errors++; $display("FAIL len_err_sticky k=%0d got=%0d side=%0d want=1/%0d",
                                 k, bus.len_err, side, k); end
    end
    do_reset();
    #1;
    checks++;
    if (bus.len_err !== 1'b0) begin errors++; $display("FAIL len_err_clear got=%0d want=0",
                                                        bus.len_err); end
  endtask

  task automatic test_back_to_back();
    int side, waited, exp;
    obs_t o;
    do_reset();
    viol = 0;
    stage(RD); stage(WR); req(RD); req(WR);
    #1;
    for (int t = 0; t < 6; t++) begin
      wait_grant(side, waited);
      exp = exp_side(1, 1);
      checks++;
      if (side !== exp || side !== (t % 2))
        begin errors++; $display("FAIL alt_grant t=%0d side=%0d want=%0d", t, side, t % 2); end
      last_rd = (exp == RD);
      stage(exp);
      serve(exp, exp == RD, exp == WR, $urandom_range(0, 2), m_len[exp] + 1, 1, o);
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL alt_exclusive viol=%0d want=0", viol); end
    clear_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int side, waited;
    obs_t o;
    do_reset();
    stage(WR); s_len[WR] = 4'd3; req(WR);
    #1; wait_grant(side, waited);
    @(negedge clk); bus.wr_valid = 0; bus.awready = 1;
    @(negedge clk); bus.awready = 0; bus.wready = 1;
    @(negedge clk); #1;
    checks++;
    if (bus.wr_data_en !== 1'b1) begin errors++; $display("FAIL mid_wd en=%0d want=1",
                                                           bus.wr_data_en); end
    stage(RD); req(RD);
    #1; rst_n = 1'b0; #1;
    checks++;
    if (all_outs() !== 64'd0)
      begin errors++; $display("FAIL mid_reset outs=%0h want=0", all_outs()); end
    clear_inputs();
    @(negedge clk); rst_n = 1'b1; last_rd = 0; len_err_exp = 0;
    @(negedge clk);
    stage(RD); stage(WR); req(RD); req(WR);
    #1; wait_grant(side, waited);
    checks++;
    if (side !== RD || waited !== 0)
      begin errors++; $display("FAIL mid_regrant side=%0d wait=%0d want=0/0", side, waited); end
    last_rd = 1;
    serve(RD, 0, 0, 0, m_len[RD] + 1, 0, o);
    wait_grant(side, waited);
    last_rd = 0;
    serve(WR, 0, 0, 0, m_len[WR] + 1, 0, o);
  endtask

  task automatic test_random();
    int side, waited, exp, ard, nb;
    bit rp, wp, nr, nw;
    obs_t o;
    do_reset();
    rp = $urandom_range(0, 1);
    wp = !rp || ($urandom_range(0, 1) == 1);
    if (rp) begin stage(RD); req(RD); end
    if (wp) begin stage(WR); req(WR); end
    #1;
    for (int it = 0; it < 30; it++) begin
      exp = exp_side(rp, wp);
      wait_grant(side, waited);
      checks++;
      if (side !== exp || waited !== 0)
        begin errors++; $display("FAIL rnd_grant it=%0d side=%0d wait=%0d want=%0d/0",
                                 it, side, waited, exp); end
      last_rd = (exp == RD);
      if (exp == RD) rp = 0; else wp = 0;
      nr = !rp && ($urandom_range(0, 1) == 1);
      nw = !wp && ($urandom_range(0, 1) == 1);
      if (!rp && !wp && !nr && !nw) begin
        if (exp == RD) nr = 1; else nw = 1;
      end
      if (nr) stage(RD);
      if (nw) stage(WR);
      ard = $urandom_range(0, 4);
      nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, m_len[exp] + 3) : m_len[exp] + 1;
      if (nb != m_len[exp] + 1) len_err_exp = 1;
      begin
        logic [ADDR_W-1:0] ea = m_addr[exp];
        logic [LEN_W-1:0]  el = m_len[exp];
        logic [ID_W-1:0]   ei = m_id[exp];
        serve(exp, nr, nw, ard, nb, 1, o);
        checks++;
        if ({o.a, o.l, o.id} !== {ea, el, ei})
          begin errors++; $display("FAIL rnd_payload it=%0d got=%0h/%0h/%0h want=%0h/%0h/%0h",
                                   it, o.a, o.l, o.id, ea, el, ei); end
      end
      checks++;
      if (!o.first_ok || !o.stable || o.vcyc !== ard + 1 || o.timeout)
        begin errors++; $display("FAIL rnd_addr it=%0d first=%0d stable=%0d cyc=%0d to=%0d want=1/1/%0d/0",
                                 it, o.first_ok, o.stable, o.vcyc, o.timeout, ard + 1); end
      checks++;
      if (o.en_bad !== 0 || o.drop !== TURN_CYC + 1 || bus.len_err !== len_err_exp)
        begin errors++; $display("FAIL rnd_data it=%0d en_bad=%0d drop=%0d len_err=%0d want=0/%0d/%0d",
                                 it, o.en_bad, o.drop, bus.len_err, TURN_CYC + 1, len_err_exp); end
      rp = rp | nr;
      wp = wp | nw;
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL rnd_exclusive viol=%0d want=0", viol); end
    clear_inputs();
    repeat (4) @(negedge clk);
  endtask

`ifdef CONV_ARB_TMO_EN
  task automatic test_timeout();
    int side, waited, cnt;
    do_reset();
    stage(RD); req(RD);
    #1; wait_grant(side, waited);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); bus.rd_valid = 0; #1;
      if (bus.arvalid) cnt++;
      else break;
    end
    checks++;
    if (cnt !== TMO_CYC || tmo_err !== 1'b1)
      begin errors++; $display("FAIL tmo_fire cyc=%0d tmo_err=%0d want=%0d/1",
                               cnt, tmo_err, TMO_CYC); end
    repeat (TURN_CYC) @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_idle busy=%0d want=0",
                                                     bus.busy); end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_tie();
    test_ar_delay();
    test_len_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef CONV_ARB_TMO_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
